// File: rtl/ssd_to_bin.sv
// ssd_to_bin: converts a pair of active-low seven-segment digits (tens, ones) to a 6-bit binary value
// using reverse double-dabble with a start/busy/done handshake and an error flag.
module ssd_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  output logic       busy,
  output logic       done,
  output logic [5:0] bin,
  output logic       err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  // returns {legal, digit}
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'h40:   dec = 5'h10;
      7'h79:   dec = 5'h11;
      7'h24:   dec = 5'h12;
      7'h30:   dec = 5'h13;
      7'h19:   dec = 5'h14;
      7'h12:   dec = 5'h15;
      7'h02:   dec = 5'h16;
      7'h78:   dec = 5'h17;
      7'h00:   dec = 5'h18;
      7'h10:   dec = 5'h19;
      default: dec = 5'h00;
    endcase
  endfunction
  function automatic logic [3:0] fix(input logic [3:0] n);
    fix = n[3] ? n - 4'd3 : n;
  endfunction
  logic [1:0]  state;
  logic [6:0]  s1, s0;
  logic [7:0]  bcd, nbcd;
  logic [5:0]  sr;
  logic [2:0]  cnt;
  logic [4:0]  t, o;
  logic        bad;
  logic [13:0] sh;
  always_comb begin
    t    = s1 == 7'h7F ? 5'h10 : dec(s1);
    o    = dec(s0);
    bad  = !t[4] || !o[4] || t[3:0] > 4'd6 || (t[3:0] == 4'd6 && o[3:0] > 4'd3);
    sh   = {bcd, sr} >> 1;
    nbcd = {fix(sh[13:10]), fix(sh[9:6])};
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      s1    <= '0;
      s0    <= '0;
      bcd   <= '0;
      sr    <= '0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            s1    <= seg1;
            s0    <= seg0;
            state <= LOAD;
          end
        LOAD:
          if (bad) begin
            bin   <= '0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            bcd   <= {t[3:0], o[3:0]};
            sr    <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        SHIFT: begin
          bcd <= nbcd;
          sr  <= sh[5:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            bin   <= sh[5:0];
            err   <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ssd_to_bin.sv
// tb_ssd_to_bin: directed-vector bench for ssd_to_bin with hand-computed results.
module tb_ssd_to_bin;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] seg1 = 7'h7F, seg0 = 7'h7F;
  logic       busy, done, err;
  logic [5:0] bin;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  ssd_to_bin dut (.clk(clk), .rst(rst), .start(start), .seg1(seg1), .seg0(seg0),
                  .busy(busy), .done(done), .bin(bin), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // sample #1 after each edge until done; lat counts edges after the accepting edge
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 30);
    if (!done) chk("timeout", 0, 1);
  endtask
  task automatic run(input string tag, input logic [6:0] a, input logic [6:0] b,
                     input logic [5:0] eb, input logic ee, input int el, input bit disturb);
    int lat, nbusy;
    @(negedge clk);
    seg1 = a; seg0 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
      if (disturb && lat == 3) begin start = 1'b1; seg1 = 7'h78; seg0 = 7'h00; end
      if (disturb && lat == 4) start = 1'b0;
    end while (!done && lat < 30);
    chk({tag, ".lat"}, lat, el);
    chk({tag, ".busy"}, nbusy, el);
    chk({tag, ".bin"}, bin, eb);
    chk({tag, ".err"}, err, ee);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {busy, done}, 0);
    chk({tag, ".hold"}, {err, bin}, {ee, eb});
  endtask
  initial begin
    int d1, d2, d3, lat, nb;
    #12;
    chk("reset", {busy, done, err, bin}, 0);
    rst = 1'b0;
    run("nom32", 7'h30, 7'h24, 6'd32, 1'b0, 7, 1'b0);
    run("zero",  7'h40, 7'h40, 6'd0,  1'b0, 7, 1'b0);
    run("blank1", 7'h7F, 7'h79, 6'd1, 1'b0, 7, 1'b0);
    run("max63", 7'h02, 7'h30, 6'd63, 1'b0, 7, 1'b0);
    run("n19",   7'h79, 7'h10, 6'd19, 1'b0, 7, 1'b0);
    run("n58",   7'h12, 7'h00, 6'd58, 1'b0, 7, 1'b0);
    run("r64",   7'h02, 7'h19, 6'd0,  1'b1, 1, 1'b0);
    run("r70",   7'h78, 7'h40, 6'd0,  1'b1, 1, 1'b0);
    run("blank0", 7'h79, 7'h7F, 6'd0, 1'b1, 1, 1'b0);
    run("ill55", 7'h55, 7'h40, 6'd0,  1'b1, 1, 1'b0);
    run("recov", 7'h19, 7'h78, 6'd47, 1'b0, 7, 1'b0);
    run("disturb", 7'h30, 7'h24, 6'd32, 1'b0, 7, 1'b1);
    // async reset mid-SHIFT after a nonzero result
    @(negedge clk);
    seg1 = 7'h02; seg0 = 7'h30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid", {busy, done, err, bin}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_nodone", {busy, done, err, bin}, 0);
    run("post_rst", 7'h24, 7'h12, 6'd25, 1'b0, 7, 1'b0);
    // back-to-back with start held high
    @(negedge clk);
    seg1 = 7'h02; seg0 = 7'h30; start = 1'b1;
    wait_done(lat, nb);
    d1 = cyc;
    chk("b2b1.bin", bin, 63);
    seg1 = 7'h79; seg0 = 7'h10;
    @(posedge clk); #1;
    chk("b2b.idle", {busy, done, bin}, {2'b00, 6'd63});
    wait_done(lat, nb);
    d2 = cyc;
    chk("b2b2.gap", d2 - d1, 9);
    chk("b2b2.bin", bin, 19);
    seg1 = 7'h40; seg0 = 7'h40;
    wait_done(lat, nb);
    d3 = cyc;
    start = 1'b0;
    chk("b2b3.gap", d3 - d2, 9);
    chk("b2b3.bin", {err, bin}, 0);
    repeat (3) @(posedge clk);
    #1 chk("b2b.stop", {busy, done}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
